arm_multiplier: RTL and testbench
=================================

ARM_MULTIPLIER -- requirements
Module: arm_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result-half width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 2: multiplier bits retired per CALC cycle; legal values 1, 2, 4, 8; must divide WIDTH.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: request a multiply; sampled only in IDLE.
REQ-006 SHALL have port op, input, 3: operation select, with these encodings:
- 000: MUL.
- 001: MLA.
- 100: UMULL.
- 101: UMLAL.
- 110: SMULL.
- 111: SMLAL.
- 010 and 011: executed as MUL.
REQ-007 SHALL have port op_a, input, WIDTH: multiplicand (Rm).
REQ-008 SHALL have port op_b, input, WIDTH: multiplier (Rs).
REQ-009 SHALL have port acc_lo, input, WIDTH: accumulate low word (Rn for MLA, RdLo for long).
REQ-010 SHALL have port acc_hi, input, WIDTH: accumulate high word (RdHi); unused for MUL/MLA.
REQ-011 SHALL have port busy, output, 1: high while an operation is in flight.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port result_lo, output, WIDTH: low result word.
REQ-014 SHALL have port result_hi, output, WIDTH: high result word; forced 0 for MUL/MLA.
REQ-015 SHALL have port n_flag, output, 1: result sign.
REQ-016 SHALL have port z_flag, output, 1: result zero.

Function
REQ-017 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-018 SHALL take these FSM transitions:
- IDLE to CALC on start=1.
- CALC to DONE after N = WIDTH/BITS_PER_CYCLE CALC cycles.
- DONE to IDLE unconditionally.
REQ-019 SHALL capture op, op_a, op_b, acc_lo and acc_hi on the accepting edge; later input changes SHALL NOT affect the operation in flight.
REQ-020 SHALL assert busy from the cycle after acceptance through the DONE cycle inclusive.
REQ-021 SHALL assert done only in the DONE cycle, for exactly one cycle.
REQ-022 SHALL have fixed latency: start sampled at edge T gives done=1 in the cycle following edge T+N+1 (N+1 edges); there is no early termination.
REQ-023 SHALL ignore start while busy=1, including the DONE cycle, so back-to-back requests are spaced N+2 cycles minimum.
REQ-024 SHALL compute MUL as result_lo = (op_a*op_b) mod 2^WIDTH.
REQ-025 SHALL compute MLA as result_lo = (op_a*op_b + acc_lo) mod 2^WIDTH.
REQ-026 SHALL compute UMULL/UMLAL as {result_hi,result_lo} = unsigned 2*WIDTH product, plus {acc_hi,acc_lo} for UMLAL, mod 2^(2*WIDTH).
REQ-027 SHALL compute SMULL/SMLAL identically, but with op_a and op_b as two's-complement; accumulate wraps mod 2^(2*WIDTH).
REQ-028 SHALL compute n_flag as bit WIDTH-1 of result_lo for MUL/MLA and bit WIDTH-1 of result_hi for long ops.
REQ-029 SHALL compute z_flag as 1 iff result_lo==0 for MUL/MLA, and iff result_hi and result_lo are both 0 for long ops.
REQ-030 SHALL produce no carry or overflow outputs.
REQ-031 SHALL update result_lo, result_hi, n_flag and z_flag only on the edge entering DONE, and SHALL hold them until the next completion.
REQ-032 SHALL keep the previous results visible during CALC.
REQ-033 SHALL use a BITS_PER_CYCLE-wide partial-product step per CALC cycle, with a 2*WIDTH accumulator and an internal cycle counter of ceil(log2(N+1)) bits.
REQ-034 SHALL handle signed operands (sign-extension or final negation) entirely within the N CALC cycles.

Reset
REQ-035 SHALL, while rst=0, asynchronously force the FSM to IDLE with busy=0, done=0, result_lo=0, result_hi=0, n_flag=0, z_flag=0, and clear the counter and accumulator.
REQ-036 SHALL, on rst asserted mid-CALC or in DONE, abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-037 SHALL be verified for MUL (WIDTH=32, BPC=2): op_a=0xFFFFFFFF, op_b=0x2 -> done exactly 17 cycles after the accepting edge, result_lo=0xFFFFFFFE, result_hi=0, n=1, z=0.
REQ-038 SHALL be verified for UMULL: op_a=op_b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, n=1, z=0.
REQ-039 SHALL be verified for SMLAL: op_a=0xFFFFFFFF, op_b=0x1, acc_hi=0, acc_lo=0x1 -> result_hi=0, result_lo=0, z=1, n=0; SMULL with the same operands -> 0xFFFFFFFF/0xFFFFFFFF, n=1.
REQ-040 SHALL be verified for MLA wrap: op_a=3, op_b=4, acc_lo=0xFFFFFFF4 -> result_lo=0, z=1; start pulsed during CALC and during DONE -> ignored, only one done pulse, busy low one cycle after DONE.
REQ-041 SHALL be verified for reset mid-op: rst=0 at CALC cycle 5 -> busy, done and results 0 immediately; new UMULL 7*9 after release -> result_lo=63 at normal latency.
REQ-042 SHALL be verified for parameter sweep WIDTH=16, BPC=4: SMULL 0x8000*0x8000 -> result_hi=0x4000, result_lo=0x0000, done 5 cycles after accept.

Source files
------------

// File: rtl/arm_multiplier.sv
// Iterative ARM-style multiplier (MUL/MLA/UMULL/UMLAL/SMULL/SMLAL) that retires
// BITS_PER_CYCLE multiplier bits per CALC cycle into a double-width accumulator.
module arm_multiplier #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             n_flag,
  output logic             z_flag
);

  localparam int unsigned K  = BITS_PER_CYCLE;
  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             long_q, long_d;
  logic             signed_q, signed_d;
  logic             bmsb_q, bmsb_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             n_q, n_d;
  logic             z_q, z_d;

  logic [PW-1:0] pp;
  logic [PW-1:0] fin;
  logic          is_long, is_sgn, is_acc;

  assign is_long = op[2];
  assign is_sgn  = op[2] & op[1];
  // 010/011 decode as plain MUL, so accumulate only for 001, 101 and 111.
  assign is_acc  = op[0] & (op[2] | ~op[1]);

  always_comb begin
    pp = '0;
    for (int unsigned j = 0; j < K; j++) begin
      if (mplier_q[j]) pp = pp + (mcand_q << j);
    end
  end

  // After N steps mcand_q holds op_a << WIDTH; a set signed multiplier MSB was
  // weighted +2^(W-1) instead of -2^(W-1), so remove 2^W * op_a once.
  assign fin = prod_q - ((signed_q && bmsb_q) ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    long_d   = long_q;
    signed_d = signed_q;
    bmsb_d   = bmsb_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    n_d      = n_q;
    z_d      = z_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StCalc;
          cnt_d    = '0;
          long_d   = is_long;
          signed_d = is_sgn;
          bmsb_d   = op_b[WIDTH-1];
          mplier_d = op_b;
          mcand_d  = is_sgn ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
          if (!is_acc)     prod_d = '0;
          else if (is_long) prod_d = {acc_hi, acc_lo};
          else              prod_d = {{WIDTH{1'b0}}, acc_lo};
        end
      end
      StCalc: begin
        if (cnt_q == CW'(N)) begin
          state_d  = StDone;
          prod_d   = fin;
          res_lo_d = fin[WIDTH-1:0];
          res_hi_d = long_q ? fin[PW-1:WIDTH] : '0;
          n_d      = long_q ? fin[PW-1] : fin[WIDTH-1];
          z_d      = long_q ? (fin == '0) : (fin[WIDTH-1:0] == '0);
        end else begin
          prod_d   = prod_q + pp;
          mcand_d  = mcand_q << K;
          mplier_d = mplier_q >> K;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      long_q   <= 1'b0;
      signed_q <= 1'b0;
      bmsb_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      long_q   <= long_d;
      signed_q <= signed_d;
      bmsb_q   <= bmsb_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      n_q      <= n_d;
      z_q      <= z_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign n_flag    = n_q;
  assign z_flag    = z_q;

endmodule

// File: tb/tb_arm_multiplier.sv
// Directed-vector bench for arm_multiplier: 32-bit/BPC=2 instance plus a
// 16-bit/BPC=4 instance for the parameter sweep.
module tb_arm_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op_a, op_b, acc_lo, acc_hi;
  logic        busy, done;
  logic [31:0] result_lo, result_hi;
  logic        n_flag, z_flag;

  logic        s_start;
  logic [2:0]  s_op;
  logic [15:0] s_op_a, s_op_b, s_acc_lo, s_acc_hi;
  logic        s_busy, s_done;
  logic [15:0] s_result_lo, s_result_hi;
  logic        s_n_flag, s_z_flag;

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat;
  int          cnt;
  logic [31:0] held_lo;

  arm_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .acc_lo    (acc_lo),
    .acc_hi    (acc_hi),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .n_flag    (n_flag),
    .z_flag    (z_flag)
  );

  arm_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .start     (s_start),
    .op        (s_op),
    .op_a      (s_op_a),
    .op_b      (s_op_b),
    .acc_lo    (s_acc_lo),
    .acc_hi    (s_acc_hi),
    .busy      (s_busy),
    .done      (s_done),
    .result_lo (s_result_lo),
    .result_hi (s_result_hi),
    .n_flag    (s_n_flag),
    .z_flag    (s_z_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect32(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                          input logic n, input logic z);
    check({tag, "_lo"}, 64'(result_lo), 64'(lo));
    check({tag, "_hi"}, 64'(result_hi), 64'(hi));
    check({tag, "_n"},  64'(n_flag),    64'(n));
    check({tag, "_z"},  64'(z_flag),    64'(z));
    held_lo = lo;
  endtask

  // Returns #1 after the edge that raised done (or after the cycle budget).
  task automatic run32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] al, input logic [31:0] ah, input bit poke,
                       output int l);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    op = o; op_a = a; op_b = b; acc_lo = al; acc_hi = ah; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = ~o; op_a = ~a; op_b = ~b; acc_lo = ~al; acc_hi = ~ah;
    check("busy_after_accept", 64'(busy), 64'd1);
    check("held_during_calc", 64'(result_lo), 64'(held_lo));
    l = 0;
    while (l < 40) begin
      @(posedge clk);
      #1;
      l++;
      start = (poke && l == 5);
      if (done) break;
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; op = '0; op_a = '0; op_b = '0; acc_lo = '0; acc_hi = '0;
    s_start = 1'b0; s_op = '0; s_op_a = '0; s_op_b = '0; s_acc_lo = '0; s_acc_hi = '0;
    held_lo = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    expect32("rst", 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;

    run32(3'b000, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 1'b0, lat);
    check("mul_latency", 64'(lat), 64'd17);
    check("mul_done", 64'(done), 64'd1);
    expect32("mul", 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0);

    run32(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, lat);
    expect32("umull", 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0);

    run32(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 1'b0, lat);
    expect32("smlal", 32'h0, 32'h0, 1'b0, 1'b1);

    run32(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 1'b0, lat);
    expect32("smull", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);

    run32(3'b110, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 1'b0, lat);
    expect32("smull_min", 32'h0, 32'h4000_0000, 1'b0, 1'b0);

    run32(3'b101, 32'h8000_0000, 32'h2, 32'hFFFF_FFFF, 32'h1, 1'b0, lat);
    expect32("umlal", 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);

    run32(3'b010, 32'h5, 32'h7, 32'd100, 32'h55, 1'b0, lat);
    expect32("op010", 32'd35, 32'h0, 1'b0, 1'b0);

    run32(3'b011, 32'h0001_0000, 32'h0001_0000, 32'h9, 32'h9, 1'b0, lat);
    expect32("op011", 32'h0, 32'h0, 1'b0, 1'b1);

    // MLA wrap with start pokes during CALC and during DONE.
    run32(3'b001, 32'd3, 32'd4, 32'hFFFF_FFF4, 32'h0, 1'b1, lat);
    check("mla_latency", 64'(lat), 64'd17);
    expect32("mla", 32'h0, 32'h0, 1'b0, 1'b1);
    op = 3'b000; op_a = 32'h1; op_b = 32'h1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
    cnt = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("no_extra_done", 64'(cnt), 64'd0);
    check("result_held_idle", 64'(result_lo), 64'h0);
    check("zflag_held_idle", 64'(z_flag), 64'd1);

    // Reset asserted at CALC cycle 5.
    @(negedge clk);
    op = 3'b100; op_a = 32'h1234; op_b = 32'h5678; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    expect32("abort", 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    run32(3'b100, 32'd7, 32'd9, 32'h0, 32'h0, 1'b0, lat);
    check("post_rst_latency", 64'(lat), 64'd17);
    expect32("post_rst", 32'd63, 32'h0, 1'b0, 1'b0);

    // 16-bit, 4 bits per cycle: SMULL 0x8000 * 0x8000.
    @(negedge clk);
    s_op = 3'b110; s_op_a = 16'h8000; s_op_b = 16'h8000; s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    s_op_a = 16'h0; s_op_b = 16'h0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (s_done) break;
    end
    check("w16_latency", 64'(lat), 64'd5);
    check("w16_hi", 64'(s_result_hi), 64'h4000);
    check("w16_lo", 64'(s_result_lo), 64'h0);
    check("w16_n", 64'(s_n_flag), 64'd0);
    check("w16_z", 64'(s_z_flag), 64'd0);
    check("w16_busy", 64'(s_busy), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
